// File: rtl/seven_segment_arbiter.sv
// Round-robin arbiter sharing one seven-segment display between NUM_REQ requesters with a minimum owner dwell.
// Optional macro SEVSEG_ARB_LOCK_EN adds req_lock so an owner in HOLD can keep the display indefinitely.
module seven_segment_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 14,
    parameter int DWELL_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_valid,
`ifdef SEVSEG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]           req_lock,
`endif
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_BITS-1:0]         data_out,
    output logic                         data_out_valid,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         owner_valid
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, DWELL, HOLD} state_t;

    state_t                            state, state_nxt, ret_state, ret_nxt;
    logic [IW-1:0]                     sel, sel_nxt, ptr, load_idx;
    logic [CW-1:0]                     cnt;
    logic [NUM_REQ-1:0][DATA_BITS-1:0] req_word;
    logic [NUM_REQ-1:0]                owner_oh;
    logic [IW:0]                       idle_res, hold_res;
    logic                              lock_hold, load, take_owner;

    // Returns {found, index}: first valid index after base with wrap; base itself is tried last if allowed.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [IW-1:0]    base,
                                            input logic             incl_base);
        logic [IW:0] r;
        int          idx;
        r = '0;
        if (incl_base && v[base]) r = {1'b1, base};
        for (int k = NUM_REQ - 1; k >= 1; k--) begin
            idx = (int'(base) + k) % NUM_REQ;
            if (v[idx]) r = {1'b1, IW'(idx)};
        end
        return r;
    endfunction

    assign req_word = req_data;
    assign owner_oh = NUM_REQ'(1) << owner;
    assign idle_res = rr_pick(req_valid, ptr, 1'b1);
    assign hold_res = rr_pick(req_valid, owner, 1'b0);

`ifdef SEVSEG_ARB_LOCK_EN
    assign lock_hold = req_lock[owner];
`else
    assign lock_hold = 1'b0;
`endif

    // In HOLD the owner's ready is withdrawn the same cycle a competitor shows up, so no owner
    // update can race the hand-over; everywhere else ready comes from registered state alone.
    always_comb begin
        state_nxt  = state;
        ret_nxt    = ret_state;
        sel_nxt    = sel;
        req_ready  = '0;
        load       = 1'b0;
        take_owner = 1'b0;
        load_idx   = owner;
        case (state)
            IDLE: begin
                if (idle_res[IW]) begin
                    sel_nxt   = idle_res[IW-1:0];
                    ret_nxt   = IDLE;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                req_ready = NUM_REQ'(1) << sel;
                if (req_valid[sel]) begin
                    load       = 1'b1;
                    load_idx   = sel;
                    take_owner = 1'b1;
                    state_nxt  = DWELL;
                end else begin
                    state_nxt = ret_state;
                end
            end
            DWELL: begin
                req_ready = owner_oh;
                load      = req_valid[owner];
                if (cnt == '0) state_nxt = HOLD;
            end
            HOLD: begin
                if (hold_res[IW] && !lock_hold) begin
                    sel_nxt   = hold_res[IW-1:0];
                    ret_nxt   = HOLD;
                    state_nxt = GRANT;
                end else begin
                    req_ready = owner_oh;
                    load      = req_valid[owner];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ret_state      <= IDLE;
            sel            <= '0;
            ptr            <= IW'(NUM_REQ - 1);
            cnt            <= '0;
            owner          <= '0;
            owner_valid    <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            ret_state      <= ret_nxt;
            sel            <= sel_nxt;
            data_out_valid <= load;
            if (load) data_out <= req_word[load_idx];
            // Owner updates during DWELL deliberately leave the counter running.
            if (take_owner) begin
                owner       <= sel;
                owner_valid <= 1'b1;
                ptr         <= sel;
                cnt         <= CW'(DWELL_CYCLES - 1);
            end else if (state == DWELL && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Directed scenarios followed by randomized traffic scored against a transaction-level model.
module tb_seven_segment_arbiter;
    localparam int N  = 4;
    localparam int DB = 14;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*DB-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DB-1:0]   data_out;
    logic            data_out_valid;
    logic [1:0]      owner;
    logic            owner_valid;
`ifdef SEVSEG_ARB_LOCK_EN
    logic [N-1:0]    req_lock;
`endif

    seven_segment_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .DWELL_CYCLES(DW)) dut (
        .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
`ifdef SEVSEG_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(req_ready), .data_out(data_out), .data_out_valid(data_out_valid),
        .owner(owner), .owner_valid(owner_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [DB-1:0] d);
        req_valid[i]          = v;
        req_data[i*DB +: DB]  = d;
    endtask

    // model state for the random phase
    int            n, t_last, pulses, hj, m_owner, m_grant, exp_rr, max_wait;
    int            waits[N];
    int            order[3];
    logic [DB-1:0] exp_vals[3];
    logic          have_owner, exp_ov, saw;
    logic [1:0]    exp_owner;
    logic [DB-1:0] exp_data;
    logic [N-1:0]  hs_vec, hs_prev, prev_valid, own_oh;

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0;
`ifdef SEVSEG_ARB_LOCK_EN
        req_lock = '0;
`endif
        repeat (3) tick();
        reset = 1'b0;
        tick(); tick();

        // 1: first grant from IDLE
        chk("rst_ready", req_ready, 0);
        chk("rst_data", data_out, 0);
        chk("rst_dv", data_out_valid, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ov", owner_valid, 0);
        set_req(2, 1'b1, 14'd1234);
        #1 chk("t1_ready_t", req_ready, 0);
        tick();
        chk("t1_ready_t1", req_ready, 4'b0100);
        chk("t1_dv_t1", data_out_valid, 0);
        tick();
        chk("t1_data", data_out, 1234);
        chk("t1_dv", data_out_valid, 1);
        chk("t1_owner", owner, 2);
        chk("t1_ov", owner_valid, 1);
        set_req(2, 1'b0, '0);

        // 2: competitor during DWELL waits out the full dwell
        set_req(1, 1'b1, 14'd55);
        #1 n = 0;
        while (!req_ready[1] && n < 40) begin tick(); n++; end
        chk("t2_wait", n, DW + 1);
        tick();
        chk("t2_data", data_out, 55);
        chk("t2_dv", data_out_valid, 1);
        chk("t2_owner", owner, 1);
        set_req(1, 1'b0, '0);

        // 3: three competitors while owner 1 is in HOLD
        repeat (DW) tick();
        order = '{2, 3, 0};
        exp_vals = '{14'd200, 14'd300, 14'd100};
        set_req(0, 1'b1, 14'd100); set_req(2, 1'b1, 14'd200); set_req(3, 1'b1, 14'd300);
        pulses = 0; t_last = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (data_out_valid) begin
                if (pulses < 3) begin
                    chk("t3_owner", owner, order[pulses]);
                    chk("t3_data", data_out, exp_vals[pulses]);
                    if (pulses > 0) chk("t3_hold_min", (t - t_last) >= DW, 1);
                    set_req(order[pulses], 1'b0, '0);
                end
                pulses++;
                t_last = t;
            end
        end
        chk("t3_pulses", pulses, 3);

        // 4: owner update mid-dwell does not extend the dwell
        set_req(2, 1'b1, 14'd77);
        tick();
        chk("t4_grant", req_ready, 4'b0100);
        tick();
        chk("t4_owner", owner, 2);
        chk("t4_data0", data_out, 77);
        set_req(2, 1'b0, '0);
        repeat (3) tick();
        set_req(2, 1'b1, 14'd4321);
        #1 chk("t4_ready_upd", req_ready, 4'b0100);
        tick();
        chk("t4_data", data_out, 4321);
        chk("t4_dv", data_out_valid, 1);
        set_req(2, 1'b0, '0);
        set_req(3, 1'b1, 14'd999);
        #1 n = 0;
        while (!req_ready[3] && n < 40) begin tick(); n++; end
        chk("t4_expiry", n, DW + 1 - 4);

        // 5: reset while granting to 3
        chk("t5_grant3", req_ready, 4'b1000);
        reset = 1'b1;
        tick();
        chk("t5_ready", req_ready, 0);
        chk("t5_data", data_out, 0);
        chk("t5_dv", data_out_valid, 0);
        chk("t5_ov", owner_valid, 0);
        chk("t5_owner", owner, 0);
        reset = 1'b0;
        set_req(1, 1'b1, 14'd11);
        tick();
        chk("t5_first", req_ready, 4'b0010);
        chk("t5_nopulse", data_out_valid, 0);
        tick();
        chk("t5_owner1", owner, 1);
        chk("t5_data1", data_out, 11);
        set_req(1, 1'b0, '0); set_req(3, 1'b0, '0);

`ifdef SEVSEG_ARB_LOCK_EN
        // 6: lock holds the display in HOLD
        reset = 1'b1; tick(); reset = 1'b0;
        set_req(0, 1'b1, 14'd5);
        tick(); tick();
        set_req(0, 1'b0, '0);
        repeat (DW) tick();
        req_lock[0] = 1'b1;
        set_req(2, 1'b1, 14'd22);
        saw = 1'b0;
        repeat (50) begin tick(); saw |= req_ready[2]; end
        chk("t6_locked", saw, 0);
        chk("t6_owner", owner, 0);
        req_lock[0] = 1'b0;
        #1 n = 0;
        while (!req_ready[2] && n < 10) begin tick(); n++; end
        chk("t6_release", n <= 2, 1);
        tick();
        set_req(2, 1'b0, '0);
`endif

        // random traffic against a transaction-level model
        reset = 1'b1; req_valid = '0; req_data = '0;
        tick();
        reset = 1'b0;
        exp_data = '0; exp_ov = 1'b0; exp_owner = '0; have_owner = 1'b0;
        m_owner = 0; m_grant = 0; max_wait = 0;
        hs_prev = '0; prev_valid = '0;
        for (int j = 0; j < N; j++) waits[j] = 0;
        for (int c = 0; c < 3000; c++) begin
            if (|hs_prev) begin
                chk("r_dv", data_out_valid, 1);
                chk("r_data", data_out, exp_data);
                chk("r_owner", owner, exp_owner);
                chk("r_ov", owner_valid, 1);
            end else begin
                chk("r_dv_idle", data_out_valid, 0);
                chk("r_data_hold", data_out, exp_data);
                chk("r_ov_hold", owner_valid, exp_ov);
                if (exp_ov) chk("r_owner_hold", owner, exp_owner);
            end
            for (int j = 0; j < N; j++) begin
                if (hs_prev[j]) begin
                    if ($urandom_range(0, 1) == 1) set_req(j, 1'b1, DB'($urandom_range(0, (1 << DB) - 1)));
                    else set_req(j, 1'b0, '0);
                end else if (!req_valid[j] && $urandom_range(0, 9) == 0) begin
                    set_req(j, 1'b1, DB'($urandom_range(0, (1 << DB) - 1)));
                end
            end
            #1;
            chk("r_onehot0", $onehot0(req_ready), 1);
            own_oh = '0;
            own_oh[m_owner] = 1'b1;
            if (have_owner && (req_ready & ~own_oh) != '0)
                chk("r_dwell_ready", (c - m_grant) >= DW + 2, 1);
            hs_vec = req_valid & req_ready;
            if (|hs_vec) begin
                hj = 0;
                for (int j = 0; j < N; j++) if (hs_vec[j]) hj = j;
                if (!have_owner || hj != m_owner) begin
                    exp_rr = -1;
                    for (int k = N; k >= 1; k--) begin
                        if (k == N && have_owner) continue;
                        if (prev_valid[((have_owner ? m_owner : N - 1) + k) % N])
                            exp_rr = ((have_owner ? m_owner : N - 1) + k) % N;
                    end
                    chk("r_rr_order", hj, exp_rr);
                    if (have_owner) chk("r_dwell_gap", (c - m_grant) >= DW + 2, 1);
                    m_owner = hj; m_grant = c; have_owner = 1'b1;
                end
                exp_data  = req_data[hj*DB +: DB];
                exp_owner = 2'(hj);
                exp_ov    = 1'b1;
            end
            for (int j = 0; j < N; j++) begin
                if (req_valid[j] && !hs_vec[j]) waits[j]++;
                else waits[j] = 0;
                if (waits[j] > max_wait) max_wait = waits[j];
            end
            prev_valid = req_valid;
            hs_prev    = hs_vec;
            tick();
        end
        chk("r_starvation", max_wait <= 80, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
